rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the rv32i instruction-fetch port (iaddr/idin) and data port (daddr/ddin/ddout/dwe0..2).
- Per-requester req/ack/rvalid handshake, one outstanding access at a time, data-over-instruction priority.
- Sits between the core (or its stall wrapper) and the memory macro; requesters use i_ack/d_ack and rvalid pulses to stall.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- MEM_LAT, 1, memory read latency in cycles (m_rdata valid MEM_LAT cycles after the m_en cycle); legal range 1..15.
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending; used only with the optional feature; legal range 1..15.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  DATA_WIDTH  instruction address.
- i_ack  out  1  request issued to memory this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  DATA_WIDTH  fetched word; holds its value between pulses.
- d_req  in  1  data request; held until d_ack.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data, byte-lane aligned as the core drives ddout.
- d_we0, d_we1, d_we2  in  1 each  lane enables: d_we0 = bits [31:24], d_we1 = [23:16], d_we2 = [15:0]. All zero means read.
- d_ack  out  1  data request issued.
- d_rvalid  out  1  completion pulse; for reads, d_rdata is valid.
- d_rdata  out  DATA_WIDTH  load data; unchanged by writes.
- m_en  out  1  memory access strobe.
- m_addr  out  DATA_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_be  out  4  byte enables = {d_we0, d_we1, d_we2, d_we2}, only on data grants.
- m_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Counter cnt is 4 bits.
- Issue is allowed in IDLE and RESP:
  - If d_req (and no forced instruction grant): grant data.
  - Else if i_req: grant instruction.
  - On a grant: that ack = 1, m_en = 1, m_addr/m_wdata/m_be come combinationally from the granted port, cnt <= MEM_LAT, next state WAIT.
  - No request: next state IDLE; m_en = 0, m_be = 0, m_addr = 0, m_wdata = 0.
- Instruction grants always drive m_be = 0 and m_wdata = 0.
- WAIT: m_en = 0, no acks, cnt decrements each cycle.
  - On the cycle cnt == 1: capture m_rdata into the granted port's rdata register (data reads only; data writes leave d_rdata unchanged).
  - Then go to RESP.
- RESP: granted port's rvalid = 1 for exactly this cycle; a new issue may occur in the same cycle.
- Timing, issue at cycle t:
  - rvalid at t+MEM_LAT+1.
  - Next issue no earlier than t+MEM_LAT+1.
  - Peak throughput: one access per MEM_LAT+1 cycles.
- The grant-owner flag is registered at issue; rvalid/rdata route by that flag, never by current req inputs.
- Handshake rules:
  - A requester may drop req before ack; no access occurs.
  - After ack, req/addr/data are don't-care; a req still high in RESP is treated as a new request.
  - Data requests are never acked while the FSM is in WAIT.
- Simultaneous i_req and d_req: data is granted and instruction waits. Without the optional feature, instruction can starve.
- Reset (any state, including WAIT or RESP):
  - Next cycle: state IDLE, cnt = 0, owner = instruction.
  - i_rvalid = d_rvalid = 0, i_rdata = d_rdata = 0.
  - In-flight response discarded, no rvalid pulse, no ack during the reset cycle.
  - Memory-side combinational outputs are 0 while rst is high.
- MEM_LAT outside 1..15: elaboration error.

Optional Feature:
- Macro: RV32I_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starve counter increments on each data grant issued while i_req = 1.
  - It clears on any instruction grant, or when i_req = 0 at an issue opportunity.
  - When the counter == STARVE_MAX and i_req = 1, the next issue grants instruction even if d_req = 1.
  - Reset clears the counter.
- Undefined: no counter is built; strict data priority; STARVE_MAX is ignored.

Test Plan:
- Single fetch, MEM_LAT=2: i_req=1, i_addr=0x10 at cycle 0; memory returns 0xDEADBEEF -> i_ack and m_en at cycle 0 with m_addr=0x10, m_be=0; i_rvalid=1 only at cycle 3 with i_rdata=0xDEADBEEF, held after.
- Contention, MEM_LAT=2: i_req (0x20) and d_req read (0x100) both at cycle 0 -> d_ack cycle 0, d_rvalid cycle 3; i_ack cycle 3, i_rvalid cycle 6.
- SH store: d_we0=1, d_we1=1, d_we2=0, d_wdata=0xABCD0000, d_addr=0x40 -> m_be=4'b1100, m_wdata=0xABCD0000; d_rvalid at t+MEM_LAT+1; d_rdata unchanged.
- Reset in WAIT (MEM_LAT=3): rst high for one cycle at t+1 -> no rvalid ever for that access; a request presented the cycle after rst drops is acked immediately.
- Starvation, STARVE_MAX=4: d_req and i_req held high continuously -> with the macro, i_ack after exactly 4 d_acks; without the macro, i_ack never asserts.
- Withdrawn request: i_req pulsed for one cycle while the FSM is in WAIT -> no i_ack, no m_en, no i_rvalid.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rv32i_mem_arbiter
//
// Shares one single-port, fixed-latency unified memory between the rv32i
// instruction-fetch port and the data port. One access is outstanding at a
// time and data requests win over instruction requests.
//
// Each requester uses a req/ack handshake. A one-cycle rvalid pulse marks
// completion, and the rdata register holds its value between pulses.
//
// Parameters
//   DATA_WIDTH  data/address width (only 32 is supported)
//   MEM_LAT     memory read latency in cycles, 1..15
//   STARVE_MAX  consecutive data grants tolerated while i_req is pending,
//               1..15 (only meaningful with the starve guard)
//
// Optional feature
//   RV32I_ARB_STARVE_GUARD_EN  when defined, a starve counter forces an
//                              instruction grant after STARVE_MAX data grants
//                              issued while i_req was pending.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                instruction read request and address
//   i_ack/i_rvalid/i_rdata      instruction issue ack, completion pulse, data
//   d_req/d_addr/d_wdata        data request, address, store data
//   d_we0/d_we1/d_we2           lane enables [31:24]/[23:16]/[15:0]; 0 = read
//   d_ack/d_rvalid/d_rdata      data issue ack, completion pulse, load data
//   m_en/m_addr/m_wdata/m_be    memory strobe, address, write data, byte enables
//   m_rdata                     memory read data, valid MEM_LAT cycles after m_en
// -----------------------------------------------------------------------------
module rv32i_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_we0,
  input  logic                  d_we1,
  input  logic                  d_we2,
  output logic                  d_ack,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_en,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_be,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("rv32i_mem_arbiter: DATA_WIDTH must be 32");
  end
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("rv32i_mem_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("rv32i_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_d_q;   // 1: access in flight belongs to data port
  logic                  d_wr_q;      // in-flight data access is a store
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  logic issue_ok;
  logic force_i;
  logic grant_d;
  logic grant_i;
  logic d_we_any;
  logic capture;

  assign d_we_any = d_we0 | d_we1 | d_we2;
  assign issue_ok = (state_q == IDLE) || (state_q == RESP);

  // Gating grants with rst keeps acks and all memory-side outputs at zero
  // during the reset cycle, whatever state the FSM is in.
  assign grant_d  = !rst && issue_ok && d_req && !force_i;
  assign grant_i  = !rst && issue_ok && i_req && !grant_d;

  // The last WAIT cycle is the one where m_rdata is valid.
  assign capture  = (state_q == WAIT) && (cnt_q == 4'd1);

`ifdef RV32I_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q;

  assign force_i = i_req && (starve_q == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (grant_i) begin
      starve_q <= 4'd0;
    end else if (issue_ok && !i_req) begin
      starve_q <= 4'd0;
    end else if (grant_d) begin
      // i_req is known high here, because the i_req == 0 case cleared above.
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so that no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    m_en    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = 4'b0000;

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant_d) begin
          d_ack   = 1'b1;
          m_en    = 1'b1;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = {d_we0, d_we1, d_we2, d_we2};
          cnt_d   = LAT;
          state_d = WAIT;
        end else if (grant_i) begin
          i_ack   = 1'b1;
          m_en    = 1'b1;
          m_addr  = i_addr;
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_d_q <= 1'b0;
      d_wr_q    <= 1'b0;
      // NOTE: the response registers are reset because 0 is the observable
      // value of rdata after reset.
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_d) begin
        owner_d_q <= 1'b1;
        d_wr_q    <= d_we_any;
      end else if (grant_i) begin
        owner_d_q <= 1'b0;
        d_wr_q    <= 1'b0;
      end
      if (capture) begin
        if (!owner_d_q) begin
          i_rdata_q <= m_rdata;
        end else if (!d_wr_q) begin
          d_rdata_q <= m_rdata;
        end
      end
    end
  end

  // Responses route by the owner flag registered at issue, never by the
  // current request inputs.
  assign i_rvalid = !rst && (state_q == RESP) && !owner_d_q;
  assign d_rvalid = !rst && (state_q == RESP) &&  owner_d_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32i_mem_arbiter
//
// Directed bench for rv32i_mem_arbiter. The main instance runs with MEM_LAT=2,
// and a second instance runs with MEM_LAT=3 for the reset-in-flight case.
//
// Completions are predicted into a scoreboard queue (port, data, cycle) when
// stimulus is driven. A monitor pops an entry on every rvalid pulse and checks
// it against the DUT output. The memory model returns a fixed function of the
// address.
// -----------------------------------------------------------------------------
module tb_rv32i_mem_arbiter;

  localparam int DW = 32;

  localparam bit GUARD =
`ifdef RV32I_ARB_STARVE_GUARD_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we0, d_we1, d_we2;
  logic [DW-1:0] i_addr, d_addr, d_wdata;
  logic          i_ack, i_rvalid, d_ack, d_rvalid, m_en;
  logic [DW-1:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]    m_be;

  // Second instance (MEM_LAT=3). Its data port is tied off.
  logic          rst3, i_req3;
  logic [DW-1:0] i_addr3;
  logic          d_req3 = 1'b0, d_we3_0 = 1'b0, d_we3_1 = 1'b0, d_we3_2 = 1'b0;
  logic [DW-1:0] d_addr3 = '0, d_wdata3 = '0;
  logic          i_ack3, i_rvalid3, d_ack3, d_rvalid3, m_en3;
  logic [DW-1:0] i_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
  logic [3:0]    m_be3;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] last_d = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32i_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_we0(d_we0), .d_we1(d_we1), .d_we2(d_we2),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata)
  );

  rv32i_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_we0(d_we3_0), .d_we1(d_we3_1), .d_we2(d_we3_2),
    .d_ack(d_ack3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_be(m_be3), .m_rdata(m_rdata3)
  );

  // Read data as a pure function of the address.
  function automatic logic [DW-1:0] rd(input logic [DW-1:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // Fixed-latency memory models. The address is captured on m_en, so data is
  // valid MEM_LAT cycles later.
  logic [DW-1:0] a2_q [4];
  logic [DW-1:0] a3_q [4];

  always @(posedge clk) begin
    if (m_en)  a2_q[0] <= m_addr;
    if (m_en3) a3_q[0] <= m_addr3;
    for (int k = 1; k < 4; k++) begin
      a2_q[k] <= a2_q[k-1];
      a3_q[k] <= a3_q[k-1];
    end
  end

  assign m_rdata  = rd(a2_q[1]);
  assign m_rdata3 = rd(a3_q[2]);

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [DW-1:0] data, input int at);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = at;
    sbq.push_back(e);
  endtask

  // Completion monitor for the main instance.
  exp_t mon_e;
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      if (sbq.size() == 0) begin
        check("unexpected_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        check("rvalid_port", {30'b0, i_rvalid, d_rvalid},
              mon_e.is_d ? 32'h1 : 32'h2);
        check("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
      end
    end
  end

  int t;
  logic exp_i;

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    i_req = 1'b0; i_addr = '0; i_req3 = 1'b0; i_addr3 = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0;
    d_we0 = 1'b0; d_we1 = 1'b0; d_we2 = 1'b0;
    tick();

    // Reset cycle with requests present: nothing is issued.
    d_req = 1'b1; d_addr = 32'h100; i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("rst_m_en",   m_en,   32'h0);
    check("rst_d_ack",  d_ack,  32'h0);
    check("rst_i_ack",  i_ack,  32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    tick();
    d_req = 1'b0; i_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_rst_i_rdata", i_rdata, 32'h0);
    check("post_rst_d_rdata", d_rdata, 32'h0);
    check("post_rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    tick();

    // Single fetch.
    t = cyc;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("fetch_i_ack",   i_ack,   32'h1);
    check("fetch_m_en",    m_en,    32'h1);
    check("fetch_m_addr",  m_addr,  32'h10);
    check("fetch_m_be",    m_be,    32'h0);
    check("fetch_m_wdata", m_wdata, 32'h0);
    push(1'b0, 32'hDEAD_BEEF, t + 3);
    tick();
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_wait_m_en", m_en, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    check("fetch_hold", i_rdata, 32'hDEAD_BEEF);
    tick();

    // Contention: data wins, instruction issues in the RESP cycle.
    t = cyc;
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h100;
    @(negedge clk);
    check("cont_d_ack",  d_ack,  32'h1);
    check("cont_i_ack0", i_ack,  32'h0);
    check("cont_m_addr", m_addr, 32'h100);
    last_d = rd(32'h100);
    push(1'b1, last_d, t + 3);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("cont_wait_i_ack", i_ack, 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("cont_i_ack",   i_ack,  32'h1);
    check("cont_i_maddr", m_addr, 32'h20);
    push(1'b0, rd(32'h20), t + 6);
    tick();
    i_req = 1'b0;
    repeat (3) tick();

    // Stores: SH to upper lanes, then a low-half store issued in RESP.
    t = cyc;
    d_req = 1'b1; d_we0 = 1'b1; d_we1 = 1'b1; d_we2 = 1'b0;
    d_wdata = 32'hABCD_0000; d_addr = 32'h40;
    @(negedge clk);
    check("sh_d_ack",   d_ack,   32'h1);
    check("sh_m_be",    m_be,    32'hC);
    check("sh_m_wdata", m_wdata, 32'hABCD_0000);
    check("sh_m_addr",  m_addr,  32'h40);
    push(1'b1, last_d, t + 3);
    tick();
    d_req = 1'b0; d_we0 = 1'b0; d_we1 = 1'b0;
    tick();
    tick();
    d_req = 1'b1; d_we2 = 1'b1; d_wdata = 32'h0000_1234; d_addr = 32'h44;
    @(negedge clk);
    check("sl_d_ack",   d_ack,   32'h1);
    check("sl_m_be",    m_be,    32'h3);
    check("sl_m_wdata", m_wdata, 32'h0000_1234);
    push(1'b1, last_d, t + 6);
    tick();
    d_req = 1'b0; d_we2 = 1'b0; d_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    check("store_d_rdata_kept", d_rdata, last_d);
    tick();

    // Instruction request withdrawn while the FSM is in WAIT.
    t = cyc;
    d_req = 1'b1; d_addr = 32'h80;
    @(negedge clk);
    check("wd_d_ack", d_ack, 32'h1);
    last_d = rd(32'h80);
    push(1'b1, last_d, t + 3);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h60;
    @(negedge clk);
    check("wd_i_ack", i_ack, 32'h0);
    check("wd_m_en",  m_en,  32'h0);
    tick();
    i_req = 1'b0;
    tick();
    @(negedge clk);
    check("wd_resp_m_en", m_en, 32'h0);
    repeat (3) tick();

    // Reset during WAIT on the MEM_LAT=3 instance.
    rst3 = 1'b0; i_req3 = 1'b1; i_addr3 = 32'h30;
    @(negedge clk);
    check("r3_first_ack", i_ack3, 32'h1);
    tick();
    rst3 = 1'b1; i_req3 = 1'b0;
    @(negedge clk);
    check("r3_rst_ack",  {31'b0, i_ack3 | d_ack3}, 32'h0);
    check("r3_rst_m_en", m_en3, 32'h0);
    tick();
    rst3 = 1'b0; i_req3 = 1'b1; i_addr3 = 32'h34;
    @(negedge clk);
    check("r3_new_ack",    i_ack3,  32'h1);
    check("r3_new_m_addr", m_addr3, 32'h34);
    tick();
    i_req3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("r3_no_rvalid", {30'b0, i_rvalid3, d_rvalid3}, 32'h0);
      tick();
    end
    @(negedge clk);
    check("r3_rvalid", i_rvalid3, 32'h1);
    check("r3_rdata",  i_rdata3,  rd(32'h34));
    tick();
    @(negedge clk);
    check("r3_rvalid_once", i_rvalid3, 32'h0);
    tick();

    // Starvation: both requests held high. Each slot issues in the previous
    // slot's RESP cycle.
    i_req = 1'b1; i_addr = 32'h50; d_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t = cyc;
      d_addr = 32'h200 + 32'(4 * k);
      exp_i = GUARD && (k == 4);
      @(negedge clk);
      check("starve_i_ack", i_ack, {31'b0, exp_i});
      check("starve_d_ack", d_ack, {31'b0, !exp_i});
      if (exp_i) begin
        push(1'b0, rd(32'h50), t + 3);
      end else begin
        last_d = rd(d_addr);
        push(1'b1, last_d, t + 3);
      end
      tick();
      @(negedge clk);
      check("starve_wait_ack", {31'b0, i_ack | d_ack}, 32'h0);
      tick();
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("starve_end_m_en", m_en, 32'h0);
    repeat (5) tick();

    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
